// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and I/O accesses onto block-RAM port A and hides the RAM read latency.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU always wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  lat_cnt_reg, lat_cnt_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              wren_reg;
  logic              we_reg;
  logic              owner_reg;
  logic              last_grant_reg, last_grant_next;
  logic [DATA_W-1:0] cpu_rdata_reg;
  logic [DATA_W-1:0] io_rdata_reg;

  logic              grant_en;
  logic              winner;
  logic              winner_we;
  logic [ADDR_W-1:0] winner_addr;
  logic [DATA_W-1:0] winner_wdata;
  logic              capture_rd;

  // Arbitration is evaluated only while idle; winner=1 selects the I/O requester.
  always_comb begin
    grant_en = (state_reg == S_IDLE) && (cpu_req || io_req);
`ifdef MEM_ARB_RR_EN
    winner = (cpu_req && io_req) ? ~last_grant_reg : ~cpu_req;
`else
    winner = ~cpu_req;
`endif
    winner_we       = winner ? io_we    : cpu_we;
    winner_addr     = winner ? io_addr  : cpu_addr;
    winner_wdata    = winner ? io_wdata : cpu_wdata;
    last_grant_next = grant_en ? winner : last_grant_reg;
    capture_rd      = (state_reg == S_WAIT) && (lat_cnt_reg == '0) && !we_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      lat_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (grant_en) state_next = S_ACCESS;
      end
      S_ACCESS: begin
        state_next   = S_WAIT;
        lat_cnt_next = LAT_LOAD;
      end
      S_WAIT: begin
        // Writes also pass through here so every access has the same latency.
        if (lat_cnt_reg == '0) state_next = S_DONE;
        else                   lat_cnt_next = lat_cnt_reg - CNT_W'(1);
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next   = S_IDLE;
        lat_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wren_reg       <= 1'b0;
      we_reg         <= 1'b0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cpu_rdata_reg  <= '0;
      io_rdata_reg   <= '0;
    end else begin
      // Write enable is high only for the single ACCESS cycle.
      wren_reg       <= grant_en & winner_we;
      last_grant_reg <= last_grant_next;
      if (grant_en) begin
        addr_reg  <= winner_addr;
        wdata_reg <= winner_wdata;
        we_reg    <= winner_we;
        owner_reg <= winner;
      end
      if (capture_rd) begin
        if (owner_reg) io_rdata_reg  <= mem_q;
        else           cpu_rdata_reg <= mem_q;
      end
    end
  end

  always_comb begin
    busy    = (state_reg != S_IDLE);
    cpu_ack = (state_reg == S_DONE) && !owner_reg;
    io_ack  = (state_reg == S_DONE) &&  owner_reg;
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wren  = wren_reg;
  assign owner     = owner_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign io_rdata  = io_rdata_reg;

endmodule
